adc_axis_master: RTL and testbench

// Packs ADC samples into a 32-bit AXI4-Stream master for the radio receive path.

---
 rtl/adc_axis_master.sv | 135 +++++++++++++
 tb/tb_adc_axis_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_axis_master.sv
// adc_axis_master: buffers sign/zero-extended ADC samples and streams them as
// fixed-length AXI4-Stream packets. The output register is one of the DEPTH
// buffer slots, so occupancy = samples in the memory + the beat being presented.
module adc_axis_master #(
    parameter int unsigned ADC_WIDTH  = 14,
    parameter int unsigned SIGNED     = 1,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PACKET_LEN = 16
) (
    input  logic                 m_axis_aclk,
    input  logic                 m_axis_areset,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [31:0]          M_AXIS_tdata,
    output logic [3:0]           M_AXIS_tstrb,
    output logic                 M_AXIS_tlast,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic                 overflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PACKET_LEN - 1);

    // Sample storage ahead of the output register
    logic [ADC_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       tdata_q, tdata_d;
    logic              tlast_q, tlast_d;
    logic              tvalid_q, tvalid_d;
    logic              overflow_q, overflow_d;

    logic [CNT_W-1:0] occ;
    logic             full;
    logic             pop;
    logic             push;
    logic             load;

    // Width extension of a raw sample to the 32-bit bus
    function automatic logic [31:0] extend(input logic [ADC_WIDTH-1:0] s);
        if (SIGNED != 0) begin
            return 32'($signed(s));
        end
        return 32'(s);
    endfunction

    // Handshake, occupancy and next-state computation
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_cnt_d  = mem_cnt_q;
        beat_d     = beat_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        overflow_d = overflow_q;

        occ  = mem_cnt_q + CNT_W'(tvalid_q);
        full = (occ == DEPTH_C);
        pop  = tvalid_q & M_AXIS_tready;
        // A full buffer still accepts a sample when a beat leaves in the same cycle
        push = adc_valid & (~full | pop);
        load = (mem_cnt_q != '0) & (~tvalid_q | pop);

        if (adc_valid & full & ~pop) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        // Beat counter advances on transfers only
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
        end

        if (load) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            tdata_d  = extend(mem_q[rd_ptr_q]);
            // The loaded beat takes the index the counter holds after this edge
            tlast_d  = (beat_d == LAST_BEAT);
            tvalid_d = 1'b1;
        end else if (pop) begin
            tlast_d  = 1'b0;
            tvalid_d = 1'b0;
        end

        mem_cnt_d = mem_cnt_q + CNT_W'(push) - CNT_W'(load);
    end

    // Control and output registers
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            beat_q     <= '0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            beat_q     <= beat_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample memory write port; contents need no reset
    always_ff @(posedge m_axis_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= adc_data;
        end
    end

    assign M_AXIS_tdata  = tdata_q;
    assign M_AXIS_tstrb  = 4'hF;
    assign M_AXIS_tlast  = tlast_q;
    assign M_AXIS_tvalid = tvalid_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_adc_axis_master.sv
// Directed bench for adc_axis_master: reset, streaming, backpressure,
// overflow, extension, full-plus-pop and back-to-back framing.
module tb_adc_axis_master;

    logic        clk;
    logic        rst;
    logic [13:0] adc_data;
    logic        adc_valid;
    logic        tready;

    logic [31:0] tdata, tdata_u;
    logic [3:0]  tstrb, tstrb_u;
    logic        tlast, tlast_u;
    logic        tvalid, tvalid_u;
    logic        overflow, overflow_u;

    int n_checks;
    int n_pass;

    adc_axis_master #(.ADC_WIDTH(14), .SIGNED(1), .DEPTH(16), .PACKET_LEN(16)) dut (
        .m_axis_aclk  (clk),
        .m_axis_areset(rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .M_AXIS_tdata (tdata),
        .M_AXIS_tstrb (tstrb),
        .M_AXIS_tlast (tlast),
        .M_AXIS_tvalid(tvalid),
        .M_AXIS_tready(tready),
        .overflow     (overflow)
    );

    adc_axis_master #(.ADC_WIDTH(14), .SIGNED(0), .DEPTH(16), .PACKET_LEN(16)) dut_u (
        .m_axis_aclk  (clk),
        .m_axis_areset(rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .M_AXIS_tdata (tdata_u),
        .M_AXIS_tstrb (tstrb_u),
        .M_AXIS_tlast (tlast_u),
        .M_AXIS_tvalid(tvalid_u),
        .M_AXIS_tready(tready),
        .overflow     (overflow_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        adc_valid = 1'b0;
        adc_data  = '0;
        tready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            adc_valid = i[0];
            adc_data  = 14'(i + 1);
            tick();
            n_checks++;
            if (tvalid !== 1'b0 || tdata !== 32'h0 || tstrb !== 4'hF || overflow !== 1'b0 || tlast !== 1'b0)
                $display("FAIL reset cyc%0d: tvalid=%b tdata=%h tstrb=%h ovf=%b tlast=%b, want 0/0/F/0/0",
                         i, tvalid, tdata, tstrb, overflow, tlast);
            else n_pass++;
        end
        n_checks++;
        if (tvalid_u !== 1'b0 || tstrb_u !== 4'hF || overflow_u !== 1'b0 || tlast_u !== 1'b0)
            $display("FAIL reset_u: tvalid=%b tstrb=%h ovf=%b tlast=%b", tvalid_u, tstrb_u, overflow_u, tlast_u);
        else n_pass++;
        adc_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        int sent = 0;
        int got  = 0;
        do_reset();
        tready = 1'b1;
        for (int cyc = 0; cyc < 300 && got < 40; cyc++) begin
            if (tvalid && tready) begin
                n_checks++;
                if (tdata !== 32'(got)) $display("FAIL stream_data beat%0d: got %h want %h", got, tdata, 32'(got));
                else n_pass++;
                n_checks++;
                if (tlast !== ((got % 16) == 15)) $display("FAIL stream_tlast beat%0d: got %b want %b", got, tlast, (got % 16) == 15);
                else n_pass++;
                got++;
            end
            adc_valid = ((cyc % 4) == 0) && (sent < 40);
            adc_data  = 14'(sent);
            if (adc_valid) sent++;
            tick();
        end
        adc_valid = 1'b0;
        n_checks++;
        if (got !== 40) $display("FAIL stream_count: got %0d beats want 40", got);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL stream_overflow: got %b want 0", overflow);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int got = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            adc_valid = 1'b1;
            adc_data  = 14'(100 + i);
            tick();
        end
        adc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== 32'd100 || tlast !== 1'b0)
                $display("FAIL bp_stall cyc%0d: tvalid=%b tdata=%h tlast=%b want 1/%h/0", i, tvalid, tdata, tlast, 32'd100);
            else n_pass++;
            tick();
        end
        tready = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
            if (tvalid) begin
                n_checks++;
                if (tdata !== 32'(100 + got)) $display("FAIL bp_data beat%0d: got %h want %h", got, tdata, 32'(100 + got));
                else n_pass++;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 8 || tvalid !== 1'b0) $display("FAIL bp_count: got %0d beats tvalid=%b want 8 and 0", got, tvalid);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL bp_overflow: got %b want 0", overflow);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int got = 0;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            adc_valid = 1'b1;
            adc_data  = 14'(200 + i);
            tick();
        end
        adc_valid = 1'b0;
        tick();
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow);
        else n_pass++;
        tready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (tvalid) begin
                n_checks++;
                if (got >= 16) $display("FAIL ovf_extra beat%0d: tdata %h, want no beat", got, tdata);
                else if (tdata !== 32'(200 + got)) $display("FAIL ovf_data beat%0d: got %h want %h", got, tdata, 32'(200 + got));
                else n_pass++;
                if (got == 15) begin
                    n_checks++;
                    if (tlast !== 1'b1) $display("FAIL ovf_tlast beat15: got %b want 1", tlast);
                    else n_pass++;
                end
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 16) $display("FAIL ovf_count: got %0d beats want 16", got);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
        else n_pass++;
    endtask

    task automatic test_extension();
        do_reset();
        adc_valid = 1'b1;
        adc_data  = 14'h2000;
        tick();
        adc_valid = 1'b0;
        tick();
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'hFFFFE000) $display("FAIL ext_signed: tvalid=%b tdata=%h want 1/FFFFE000", tvalid, tdata);
        else n_pass++;
        n_checks++;
        if (tvalid_u !== 1'b1 || tdata_u !== 32'h00002000) $display("FAIL ext_unsigned: tvalid=%b tdata=%h want 1/00002000", tvalid_u, tdata_u);
        else n_pass++;
        tready = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 14'h1FFF;
        tick();
        adc_valid = 1'b0;
        tick();
        n_checks++;
        if (tdata !== 32'h00001FFF || tdata_u !== 32'h00001FFF || tvalid !== 1'b1)
            $display("FAIL ext_positive: tdata=%h tdata_u=%h tvalid=%b want 1FFF/1FFF/1", tdata, tdata_u, tvalid);
        else n_pass++;
        tick();
        n_checks++;
        if (tvalid !== 1'b0 || tdata !== 32'h00001FFF) $display("FAIL ext_empty_hold: tvalid=%b tdata=%h want 0/00001FFF", tvalid, tdata);
        else n_pass++;
        n_checks++;
        if (overflow_u !== 1'b0 || tstrb_u !== 4'hF || tlast_u !== 1'b0)
            $display("FAIL ext_u_misc: ovf=%b tstrb=%h tlast=%b want 0/F/0", overflow_u, tstrb_u, tlast_u);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        int got = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            adc_valid = 1'b1;
            adc_data  = 14'(300 + i);
            tick();
        end
        adc_data = 14'd316;
        tready   = 1'b1;
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 32'd300) $display("FAIL fp_head: tvalid=%b tdata=%h want 1/%h", tvalid, tdata, 32'd300);
        else n_pass++;
        got = 1;
        tick();
        adc_valid = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 17; cyc++) begin
            if (tvalid) begin
                n_checks++;
                if (tdata !== 32'(300 + got)) $display("FAIL fp_data beat%0d: got %h want %h", got, tdata, 32'(300 + got));
                else n_pass++;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 17) $display("FAIL fp_count: got %0d beats want 17", got);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL fp_overflow: got %b want 0", overflow);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int first = -1;
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adc_valid = 1'b1;
            adc_data  = 14'(i);
            tick();
        end
        adc_valid = 1'b0;
        tick();
        // Reset part-way through a packet; framing must restart at beat 0
        rst = 1'b1;
        #2;
        n_checks++;
        if (tvalid !== 1'b0 || tdata !== 32'h0) $display("FAIL async_reset: tvalid=%b tdata=%h want 0/0", tvalid, tdata);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            if (tvalid) begin
                if (first < 0) first = cyc;
                n_checks++;
                if (tdata !== 32'(500 + got) || tlast !== (got == 15) || (cyc - first) !== got)
                    $display("FAIL b2b beat%0d: tdata=%h tlast=%b slot=%0d want %h/%b/%0d",
                             got, tdata, tlast, cyc - first, 32'(500 + got), got == 15, got);
                else n_pass++;
                got++;
            end
            adc_valid = (cyc < 16);
            adc_data  = 14'(500 + cyc);
            tick();
        end
        adc_valid = 1'b0;
        n_checks++;
        if (got !== 16) $display("FAIL b2b_count: got %0d beats want 16", got);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        adc_valid = 1'b0;
        adc_data  = '0;
        tready    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_overflow();
        test_extension();
        test_full_pop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
